// File: rtl/factor_rebuild.sv
// factor_rebuild: multiplies a factor stream back into a product and
// compares it with the latched target, flagging any W-bit overflow.
//
// Ports:
//   clk, reset        rising-edge clock, async active-high reset
//   Start, InA        begin a job (IDLE only), target operand
//   FacValid/FacData/FacLast/FacReady
//                     factor stream handshake; FacLast marks the final factor
//   Busy, Done        job in progress, one-cycle result pulse
//   Match, Ovf        product equals target, sticky overflow
//   Product, FacCnt   low W bits of the product, saturating factor count
module factor_rebuild #(
  parameter int W    = 8,
  parameter int CNTW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  logic [W-1:0]    InA,
  input  logic            FacValid,
  input  logic [W-1:0]    FacData,
  input  logic            FacLast,
  output logic            FacReady,
  output logic            Busy,
  output logic            Done,
  output logic            Match,
  output logic            Ovf,
  output logic [W-1:0]    Product,
  output logic [CNTW-1:0] FacCnt
);

  localparam int BW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_MUL,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [W-1:0]    tgt_q;
  logic [W-1:0]    prod_q;
  logic [W-1:0]    mcand_q;
  logic [W-1:0]    mplier_q;
  logic [2*W-1:0]  acc_q;
  logic [BW-1:0]   bit_q;
  logic            last_q;
  logic            ovf_q;
  logic            match_q;
  logic            done_q;
  logic            busy_q;
  logic [CNTW-1:0] cnt_q;

  logic [2*W-1:0]  pp;
  logic [2*W-1:0]  acc_d;
  logic            step_end;
  logic            ovf_d;
  logic            match_d;

  // One shift-add step; the final step's sum is the new product.
  always_comb begin
    pp = '0;
    if (mplier_q[bit_q]) begin
      pp = {{W{1'b0}}, mcand_q} << bit_q;
    end
    acc_d    = acc_q + pp;
    step_end = (bit_q == BW'(W - 1));
    ovf_d    = ovf_q | (|acc_d[2*W-1:W]);
    match_d  = !ovf_d && (acc_d[W-1:0] == tgt_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tgt_q    <= '0;
      prod_q   <= {{(W-1){1'b0}}, 1'b1};
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      bit_q    <= '0;
      last_q   <= 1'b0;
      ovf_q    <= 1'b0;
      match_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (Start) begin
            tgt_q   <= InA;
            prod_q  <= {{(W-1){1'b0}}, 1'b1};
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            match_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (FacValid) begin
            mcand_q  <= prod_q;
            mplier_q <= FacData;
            acc_q    <= '0;
            bit_q    <= '0;
            last_q   <= FacLast;
            if (!(&cnt_q)) begin
              cnt_q <= cnt_q + CNTW'(1);
            end
            state_q  <= S_MUL;
          end
        end
        S_MUL: begin
          acc_q <= acc_d;
          bit_q <= bit_q + BW'(1);
          if (step_end) begin
            prod_q <= acc_d[W-1:0];
            ovf_q  <= ovf_d;
            if (last_q) begin
              // Match is judged on the values entering DONE.
              match_q <= match_d;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Ready is a pure state decode so the sender sees no input-to-output path.
  assign FacReady = (state_q == S_WAIT);
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Match    = match_q;
  assign Ovf      = ovf_q;
  assign Product  = prod_q;
  assign FacCnt   = cnt_q;

endmodule

// File: doc/factor_rebuild.md
Name: factor_rebuild

Overview:
- Checker block that performs the inverse of the factorization core: it multiplies a stream of factors back into a product and compares the result to the original target.
- Placed on the result side of the factorization datapath. Receives the target operand plus the factor stream over a valid/ready handshake.
- Uses a sequential shift-add multiplier, one factor at a time, with a sticky overflow flag.
- Reports Product, Match, Ovf and factor count, with a one-cycle Done pulse.

Parameters:
- W, 8, operand/factor/product width in bits.
- CNTW, 4, width of the factor counter (saturating).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Start  in  1  begin a check job; sampled only in IDLE.
- InA  in  W  target value; latched on an accepted Start.
- FacValid  in  1  factor word valid.
- FacData  in  W  factor value.
- FacLast  in  1  marks the final factor of the job; qualified by FacValid.
- FacReady  out  1  block can accept a factor this cycle.
- Busy  out  1  high from accepted Start until return to IDLE.
- Done  out  1  one-cycle pulse when the result is valid.
- Match  out  1  result flag; valid while Done is high and held until the next Start.
- Ovf  out  1  sticky flag: the product exceeded W bits at some step.
- Product  out  W  low W bits of the running/final product.
- FacCnt  out  CNTW  number of accepted factors, saturating at 2^CNTW-1.

Behaviour:
- Reset (asynchronous): state goes to IDLE. Product=1, FacCnt=0, Ovf=0, Match=0, Done=0, Busy=0, FacReady=0; target register cleared.
- States: IDLE, WAIT, MUL, DONE.
- IDLE:
  - Busy=0, FacReady=0.
  - On Start=1 at a rising edge: target<=InA, Product<=1, FacCnt<=0, Ovf<=0, Match<=0; state goes to WAIT.
- WAIT:
  - Busy=1, FacReady=1. Factors arriving outside WAIT are not accepted; the sender holds them.
  - A factor is accepted on an edge with FacValid&FacReady. On acceptance: multiplicand<=Product, multiplier<=FacData, 2W-bit accumulator<=0, bit counter<=0, last flag<=FacLast, FacCnt<=FacCnt+1 (saturating); state goes to MUL.
- MUL:
  - Exactly W cycles, with Busy=1 and FacReady=0.
  - Each cycle: if multiplier bit[count] is set, add (multiplicand<<count) to the accumulator; count increments.
  - On the W-th cycle edge: Product<=acc[W-1:0]; Ovf<=Ovf | (acc[2W-1:W]!=0). The next state is DONE if the last flag is set, otherwise WAIT.
  - Factor-to-factor throughput is W+1 cycles: accept edge k, result at edge k+W, FacReady high again after edge k+W.
- DONE:
  - Held for one cycle. Done=1, Busy=1, Match = (!Ovf && Product==target). Match is registered on entry to DONE.
  - Next state is IDLE. Match, Ovf, Product and FacCnt hold until the next accepted Start.
- Arithmetic:
  - Unsigned. Product is always the low W bits; after an overflow, Ovf stays set for the rest of the job.
  - Factor 0 gives Product=0; Match=1 only if the target is 0 and Ovf=0. Factor 1 leaves Product unchanged.
- Boundary conditions:
  - Start outside IDLE is ignored, with no restart.
  - FacLast without FacValid is ignored.
  - At FacCnt saturation, counting stops but multiplication continues.
  - Reset asserted in any state, including mid-MUL, aborts immediately to reset values. No partial Done is issued.
  - Start and reset asserted together: reset wins.
- No combinational path from inputs to outputs except FacReady, which depends only on state.

Test Plan:
- Start with InA=12; factors 2, 2, 3(last) -> Done pulse 1 cycle after the third MUL completes. Product=12, Match=1, Ovf=0, FacCnt=3; FacReady low exactly 8 cycles after each accept.
- InA=60; factors 2, 3, 2, 5(last), with FacValid gaps of 0-5 random cycles -> Product=60, Match=1, FacCnt=4. Total cycles = 4x9 + gaps + DONE.
- InA=200; factors 16, 16(last) -> Product=0x00, Ovf=1, Match=0. Also InA=13; factor 7(last) -> Product=7, Match=0, Ovf=0.
- InA=0; factors 0, 5(last) -> Product=0, Match=1. Also InA=13; factor 13(last) -> Match=1, FacCnt=1.
- Assert Start in WAIT and in MUL -> ignored, target unchanged. Hold FacValid high during MUL -> no extra accept, FacCnt increments once per handshake only.
- Pulse reset asynchronously at the 4th cycle of MUL -> outputs return to reset values before the next edge, no Done. A subsequent Start with InA=6; factors 2, 3(last) -> Match=1.
